// File: rtl/armleo_axi_mux_rw.sv
// ============================================================================
// armleo_axi_mux_rw : N-host to 1-client AXI4 mux, independent R/W arbitration
// Revision: 1.0
// ============================================================================
`default_nettype none

module armleo_axi_mux_rw #(
  parameter int HOST_NUMBER = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  localparam int IDX_W        = (HOST_NUMBER > 2) ? $clog2(HOST_NUMBER) : 1,
  localparam int DATA_STROBES = DATA_WIDTH / 8,
  localparam int c_DID_W      = ID_WIDTH + IDX_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,

  input  logic [HOST_NUMBER-1:0]                  upstream_axi_awvalid,
  output logic [HOST_NUMBER-1:0]                  upstream_axi_awready,
  input  logic [HOST_NUMBER-1:0][ADDR_WIDTH-1:0]  upstream_axi_awaddr,
  input  logic [HOST_NUMBER-1:0][7:0]             upstream_axi_awlen,
  input  logic [HOST_NUMBER-1:0][2:0]             upstream_axi_awsize,
  input  logic [HOST_NUMBER-1:0][1:0]             upstream_axi_awburst,
  input  logic [HOST_NUMBER-1:0]                  upstream_axi_awlock,
  input  logic [HOST_NUMBER-1:0][ID_WIDTH-1:0]    upstream_axi_awid,
  input  logic [HOST_NUMBER-1:0][2:0]             upstream_axi_awprot,

  input  logic [HOST_NUMBER-1:0]                  upstream_axi_wvalid,
  output logic [HOST_NUMBER-1:0]                  upstream_axi_wready,
  input  logic [HOST_NUMBER-1:0][DATA_WIDTH-1:0]  upstream_axi_wdata,
  input  logic [HOST_NUMBER-1:0][DATA_STROBES-1:0] upstream_axi_wstrb,
  input  logic [HOST_NUMBER-1:0]                  upstream_axi_wlast,

  output logic [HOST_NUMBER-1:0]                  upstream_axi_bvalid,
  input  logic [HOST_NUMBER-1:0]                  upstream_axi_bready,
  output logic [HOST_NUMBER-1:0][1:0]             upstream_axi_bresp,
  output logic [HOST_NUMBER-1:0][ID_WIDTH-1:0]    upstream_axi_bid,

  input  logic [HOST_NUMBER-1:0]                  upstream_axi_arvalid,
  output logic [HOST_NUMBER-1:0]                  upstream_axi_arready,
  input  logic [HOST_NUMBER-1:0][ADDR_WIDTH-1:0]  upstream_axi_araddr,
  input  logic [HOST_NUMBER-1:0][7:0]             upstream_axi_arlen,
  input  logic [HOST_NUMBER-1:0][2:0]             upstream_axi_arsize,
  input  logic [HOST_NUMBER-1:0][1:0]             upstream_axi_arburst,
  input  logic [HOST_NUMBER-1:0]                  upstream_axi_arlock,
  input  logic [HOST_NUMBER-1:0][ID_WIDTH-1:0]    upstream_axi_arid,
  input  logic [HOST_NUMBER-1:0][2:0]             upstream_axi_arprot,

  output logic [HOST_NUMBER-1:0]                  upstream_axi_rvalid,
  input  logic [HOST_NUMBER-1:0]                  upstream_axi_rready,
  output logic [HOST_NUMBER-1:0][1:0]             upstream_axi_rresp,
  output logic [HOST_NUMBER-1:0]                  upstream_axi_rlast,
  output logic [HOST_NUMBER-1:0][DATA_WIDTH-1:0]  upstream_axi_rdata,
  output logic [HOST_NUMBER-1:0][ID_WIDTH-1:0]    upstream_axi_rid,

  output logic                                    downstream_axi_awvalid,
  input  logic                                    downstream_axi_awready,
  output logic [ADDR_WIDTH-1:0]                   downstream_axi_awaddr,
  output logic [7:0]                              downstream_axi_awlen,
  output logic [2:0]                              downstream_axi_awsize,
  output logic [1:0]                              downstream_axi_awburst,
  output logic                                    downstream_axi_awlock,
  output logic [c_DID_W-1:0]                      downstream_axi_awid,
  output logic [2:0]                              downstream_axi_awprot,

  output logic                                    downstream_axi_wvalid,
  input  logic                                    downstream_axi_wready,
  output logic [DATA_WIDTH-1:0]                   downstream_axi_wdata,
  output logic [DATA_STROBES-1:0]                 downstream_axi_wstrb,
  output logic                                    downstream_axi_wlast,

  input  logic                                    downstream_axi_bvalid,
  output logic                                    downstream_axi_bready,
  input  logic [1:0]                              downstream_axi_bresp,
  input  logic [c_DID_W-1:0]                      downstream_axi_bid,

  output logic                                    downstream_axi_arvalid,
  input  logic                                    downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0]                   downstream_axi_araddr,
  output logic [7:0]                              downstream_axi_arlen,
  output logic [2:0]                              downstream_axi_arsize,
  output logic [1:0]                              downstream_axi_arburst,
  output logic                                    downstream_axi_arlock,
  output logic [c_DID_W-1:0]                      downstream_axi_arid,
  output logic [2:0]                              downstream_axi_arprot,

  input  logic                                    downstream_axi_rvalid,
  output logic                                    downstream_axi_rready,
  input  logic [1:0]                              downstream_axi_rresp,
  input  logic                                    downstream_axi_rlast,
  input  logic [DATA_WIDTH-1:0]                   downstream_axi_rdata,
  input  logic [c_DID_W-1:0]                      downstream_axi_rid
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACTIVE = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

  w_state_t         r_wstate;
  r_state_t         r_rstate;
  logic [IDX_W-1:0] r_wsel, r_wptr, r_rsel, r_rptr;
  logic             r_aw_done, r_w_done;

  logic [IDX_W:0]   w_aw_pick, w_ar_pick;
  logic             w_aw_src_valid, w_w_src_valid, w_ar_src_valid;
  logic [ID_WIDTH-1:0] w_awid_sel, w_arid_sel;
  logic             w_aw_hs, w_w_last_hs, w_b_hs, w_ar_hs, w_r_last_hs;
  logic             w_bhit, w_bready_host, w_rhit, w_rready_host;
  logic [IDX_W-1:0] w_bprefix, w_rprefix;

  // Returns {found, index}; search begins one past the last grant and wraps.
  function automatic logic [IDX_W:0] rr_pick(input logic [HOST_NUMBER-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               c;
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k <= HOST_NUMBER; k++) begin
      c = (int'(ptr) + k) % HOST_NUMBER;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
    return {found, idx};
  endfunction

  assign w_aw_pick = rr_pick(upstream_axi_awvalid, r_wptr);
  assign w_ar_pick = rr_pick(upstream_axi_arvalid, r_rptr);

  assign w_aw_hs     = downstream_axi_awvalid && downstream_axi_awready;
  assign w_w_last_hs = downstream_axi_wvalid && downstream_axi_wready && downstream_axi_wlast;
  assign w_b_hs      = downstream_axi_bvalid && downstream_axi_bready;
  assign w_ar_hs     = downstream_axi_arvalid && downstream_axi_arready;
  assign w_r_last_hs = downstream_axi_rvalid && downstream_axi_rready && downstream_axi_rlast;

  assign w_bprefix = downstream_axi_bid[c_DID_W-1:ID_WIDTH];
  assign w_rprefix = downstream_axi_rid[c_DID_W-1:ID_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_wsel    <= '0;
      r_wptr    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_pick[IDX_W]) begin
          r_wsel    <= w_aw_pick[IDX_W-1:0];
          r_wptr    <= w_aw_pick[IDX_W-1:0];
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_wstate  <= W_ACTIVE;
        end
        W_ACTIVE: begin
          if (w_aw_hs)     r_aw_done <= 1'b1;
          if (w_w_last_hs) r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_last_hs))
            r_wstate <= W_RESP;
        end
        W_RESP: if (w_b_hs) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rsel   <= '0;
      r_rptr   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_pick[IDX_W]) begin
          r_rsel   <= w_ar_pick[IDX_W-1:0];
          r_rptr   <= w_ar_pick[IDX_W-1:0];
          r_rstate <= R_ADDR;
        end
        R_ADDR:  if (w_ar_hs) r_rstate <= R_DATA;
        R_DATA:  if (w_r_last_hs) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write address/data forwarding from the granted host
  always_comb begin
    downstream_axi_awaddr  = upstream_axi_awaddr[0];
    downstream_axi_awlen   = upstream_axi_awlen[0];
    downstream_axi_awsize  = upstream_axi_awsize[0];
    downstream_axi_awburst = upstream_axi_awburst[0];
    downstream_axi_awlock  = upstream_axi_awlock[0];
    downstream_axi_awprot  = upstream_axi_awprot[0];
    w_awid_sel             = upstream_axi_awid[0];
    w_aw_src_valid         = 1'b0;
    downstream_axi_wdata   = upstream_axi_wdata[0];
    downstream_axi_wstrb   = upstream_axi_wstrb[0];
    downstream_axi_wlast   = upstream_axi_wlast[0];
    w_w_src_valid          = 1'b0;
    upstream_axi_awready   = '0;
    upstream_axi_wready    = '0;
    for (int h = 0; h < HOST_NUMBER; h++) begin
      if (r_wsel == IDX_W'(h)) begin
        downstream_axi_awaddr  = upstream_axi_awaddr[h];
        downstream_axi_awlen   = upstream_axi_awlen[h];
        downstream_axi_awsize  = upstream_axi_awsize[h];
        downstream_axi_awburst = upstream_axi_awburst[h];
        downstream_axi_awlock  = upstream_axi_awlock[h];
        downstream_axi_awprot  = upstream_axi_awprot[h];
        w_awid_sel             = upstream_axi_awid[h];
        w_aw_src_valid         = upstream_axi_awvalid[h];
        downstream_axi_wdata   = upstream_axi_wdata[h];
        downstream_axi_wstrb   = upstream_axi_wstrb[h];
        downstream_axi_wlast   = upstream_axi_wlast[h];
        w_w_src_valid          = upstream_axi_wvalid[h];
        upstream_axi_awready[h] = (r_wstate == W_ACTIVE) && !r_aw_done && downstream_axi_awready;
        upstream_axi_wready[h]  = (r_wstate == W_ACTIVE) && !r_w_done && downstream_axi_wready;
      end
    end
    downstream_axi_awid   = {r_wsel, w_awid_sel};
    downstream_axi_awvalid = (r_wstate == W_ACTIVE) && !r_aw_done && w_aw_src_valid;
    downstream_axi_wvalid  = (r_wstate == W_ACTIVE) && !r_w_done && w_w_src_valid;
  end

  // Read address forwarding from the granted host
  always_comb begin
    downstream_axi_araddr  = upstream_axi_araddr[0];
    downstream_axi_arlen   = upstream_axi_arlen[0];
    downstream_axi_arsize  = upstream_axi_arsize[0];
    downstream_axi_arburst = upstream_axi_arburst[0];
    downstream_axi_arlock  = upstream_axi_arlock[0];
    downstream_axi_arprot  = upstream_axi_arprot[0];
    w_arid_sel             = upstream_axi_arid[0];
    w_ar_src_valid         = 1'b0;
    upstream_axi_arready   = '0;
    for (int h = 0; h < HOST_NUMBER; h++) begin
      if (r_rsel == IDX_W'(h)) begin
        downstream_axi_araddr  = upstream_axi_araddr[h];
        downstream_axi_arlen   = upstream_axi_arlen[h];
        downstream_axi_arsize  = upstream_axi_arsize[h];
        downstream_axi_arburst = upstream_axi_arburst[h];
        downstream_axi_arlock  = upstream_axi_arlock[h];
        downstream_axi_arprot  = upstream_axi_arprot[h];
        w_arid_sel             = upstream_axi_arid[h];
        w_ar_src_valid         = upstream_axi_arvalid[h];
        upstream_axi_arready[h] = (r_rstate == R_ADDR) && downstream_axi_arready;
      end
    end
    downstream_axi_arid    = {r_rsel, w_arid_sel};
    downstream_axi_arvalid = (r_rstate == R_ADDR) && w_ar_src_valid;
  end

  // Responses are broadcast; only the host named by the id prefix sees valid.
  // An unknown prefix is drained so the bus cannot stall.
  always_comb begin
    upstream_axi_bvalid = '0;
    upstream_axi_rvalid = '0;
    w_bhit        = 1'b0;
    w_bready_host = 1'b0;
    w_rhit        = 1'b0;
    w_rready_host = 1'b0;
    for (int h = 0; h < HOST_NUMBER; h++) begin
      upstream_axi_bresp[h] = downstream_axi_bresp;
      upstream_axi_bid[h]   = downstream_axi_bid[ID_WIDTH-1:0];
      upstream_axi_rresp[h] = downstream_axi_rresp;
      upstream_axi_rlast[h] = downstream_axi_rlast;
      upstream_axi_rdata[h] = downstream_axi_rdata;
      upstream_axi_rid[h]   = downstream_axi_rid[ID_WIDTH-1:0];
      if (w_bprefix == IDX_W'(h)) begin
        w_bhit                 = 1'b1;
        w_bready_host          = upstream_axi_bready[h];
        upstream_axi_bvalid[h] = (r_wstate == W_RESP) && downstream_axi_bvalid;
      end
      if (w_rprefix == IDX_W'(h)) begin
        w_rhit                 = 1'b1;
        w_rready_host          = upstream_axi_rready[h];
        upstream_axi_rvalid[h] = (r_rstate == R_DATA) && downstream_axi_rvalid;
      end
    end
    downstream_axi_bready = (r_wstate == W_RESP) && (w_bhit ? w_bready_host : 1'b1);
    downstream_axi_rready = (r_rstate == R_DATA) && (w_rhit ? w_rready_host : 1'b1);
  end

endmodule

`default_nettype wire

// File: tb/tb_armleo_axi_mux_rw.sv
// ============================================================================
// tb_armleo_axi_mux_rw : directed self-checking bench for armleo_axi_mux_rw
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_armleo_axi_mux_rw;
  localparam int HN = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DID = IW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [HN-1:0]          up_awvalid, up_awready, up_awlock;
  logic [HN-1:0][AW-1:0]  up_awaddr, up_araddr;
  logic [HN-1:0][7:0]     up_awlen, up_arlen;
  logic [HN-1:0][2:0]     up_awsize, up_awprot, up_arsize, up_arprot;
  logic [HN-1:0][1:0]     up_awburst, up_arburst, up_bresp, up_rresp;
  logic [HN-1:0][IW-1:0]  up_awid, up_arid, up_bid, up_rid;
  logic [HN-1:0]          up_wvalid, up_wready, up_wlast, up_bvalid, up_bready;
  logic [HN-1:0][DW-1:0]  up_wdata, up_rdata;
  logic [HN-1:0][DW/8-1:0] up_wstrb;
  logic [HN-1:0]          up_arvalid, up_arready, up_arlock, up_rvalid, up_rready, up_rlast;

  logic           dn_awvalid, dn_awready, dn_awlock, dn_wvalid, dn_wready, dn_wlast;
  logic [AW-1:0]  dn_awaddr, dn_araddr;
  logic [7:0]     dn_awlen, dn_arlen;
  logic [2:0]     dn_awsize, dn_awprot, dn_arsize, dn_arprot;
  logic [1:0]     dn_awburst, dn_arburst, dn_bresp, dn_rresp;
  logic [DID-1:0] dn_awid, dn_bid, dn_arid, dn_rid;
  logic [DW-1:0]  dn_wdata, dn_rdata;
  logic [DW/8-1:0] dn_wstrb;
  logic           dn_bvalid, dn_bready, dn_arvalid, dn_arready, dn_arlock;
  logic           dn_rvalid, dn_rready, dn_rlast;

  int errors = 0;
  int checks = 0;

  armleo_axi_mux_rw #(.HOST_NUMBER(HN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .upstream_axi_awvalid(up_awvalid), .upstream_axi_awready(up_awready),
    .upstream_axi_awaddr(up_awaddr), .upstream_axi_awlen(up_awlen),
    .upstream_axi_awsize(up_awsize), .upstream_axi_awburst(up_awburst),
    .upstream_axi_awlock(up_awlock), .upstream_axi_awid(up_awid), .upstream_axi_awprot(up_awprot),
    .upstream_axi_wvalid(up_wvalid), .upstream_axi_wready(up_wready), .upstream_axi_wdata(up_wdata),
    .upstream_axi_wstrb(up_wstrb), .upstream_axi_wlast(up_wlast),
    .upstream_axi_bvalid(up_bvalid), .upstream_axi_bready(up_bready),
    .upstream_axi_bresp(up_bresp), .upstream_axi_bid(up_bid),
    .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
    .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen),
    .upstream_axi_arsize(up_arsize), .upstream_axi_arburst(up_arburst),
    .upstream_axi_arlock(up_arlock), .upstream_axi_arid(up_arid), .upstream_axi_arprot(up_arprot),
    .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready), .upstream_axi_rresp(up_rresp),
    .upstream_axi_rlast(up_rlast), .upstream_axi_rdata(up_rdata), .upstream_axi_rid(up_rid),
    .downstream_axi_awvalid(dn_awvalid), .downstream_axi_awready(dn_awready),
    .downstream_axi_awaddr(dn_awaddr), .downstream_axi_awlen(dn_awlen),
    .downstream_axi_awsize(dn_awsize), .downstream_axi_awburst(dn_awburst),
    .downstream_axi_awlock(dn_awlock), .downstream_axi_awid(dn_awid), .downstream_axi_awprot(dn_awprot),
    .downstream_axi_wvalid(dn_wvalid), .downstream_axi_wready(dn_wready), .downstream_axi_wdata(dn_wdata),
    .downstream_axi_wstrb(dn_wstrb), .downstream_axi_wlast(dn_wlast),
    .downstream_axi_bvalid(dn_bvalid), .downstream_axi_bready(dn_bready),
    .downstream_axi_bresp(dn_bresp), .downstream_axi_bid(dn_bid),
    .downstream_axi_arvalid(dn_arvalid), .downstream_axi_arready(dn_arready),
    .downstream_axi_araddr(dn_araddr), .downstream_axi_arlen(dn_arlen),
    .downstream_axi_arsize(dn_arsize), .downstream_axi_arburst(dn_arburst),
    .downstream_axi_arlock(dn_arlock), .downstream_axi_arid(dn_arid), .downstream_axi_arprot(dn_arprot),
    .downstream_axi_rvalid(dn_rvalid), .downstream_axi_rready(dn_rready), .downstream_axi_rresp(dn_rresp),
    .downstream_axi_rlast(dn_rlast), .downstream_axi_rdata(dn_rdata), .downstream_axi_rid(dn_rid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    up_awvalid = '0; up_awaddr = '0; up_awlen = '0; up_awsize = '0; up_awburst = '0;
    up_awlock = '0; up_awid = '0; up_awprot = '0;
    up_wvalid = '0; up_wdata = '0; up_wstrb = '1; up_wlast = '0; up_bready = '0;
    up_arvalid = '0; up_araddr = '0; up_arlen = '0; up_arsize = '0; up_arburst = '0;
    up_arlock = '0; up_arid = '0; up_arprot = '0; up_rready = '0;
    dn_awready = 1'b0; dn_wready = 1'b0; dn_bvalid = 1'b0; dn_bresp = '0; dn_bid = '0;
    dn_arready = 1'b0; dn_rvalid = 1'b0; dn_rresp = '0; dn_rlast = 1'b0; dn_rdata = '0; dn_rid = '0;
  endtask

  // Single-requester write burst from host h, driven and checked end to end.
  task automatic do_write(input int h, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input int nbeats);
    logic [1:0] hx;
    hx = 2'(h);
    up_awvalid[h] = 1'b1; up_awaddr[h] = addr; up_awlen[h] = 8'(nbeats - 1); up_awid[h] = id;
    settle();
    chk("idle_awready", up_awready, 0);
    chk("idle_dn_awvalid", dn_awvalid, 0);
    cyc();
    chk("wr_dn_awvalid", dn_awvalid, 1);
    chk("wr_awid", dn_awid, {hx, id});
    chk("wr_awaddr", dn_awaddr, addr);
    chk("wr_awlen", dn_awlen, nbeats - 1);
    dn_awready = 1'b1;
    settle();
    chk("wr_awready_route", up_awready, 4'b0001 << h);
    cyc();
    up_awvalid[h] = 1'b0; dn_awready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      up_wvalid[h] = 1'b1; up_wdata[h] = 32'hD000_0000 + 32'(h * 256 + i);
      up_wlast[h] = (i == nbeats - 1); dn_wready = 1'b1;
      settle();
      chk("wr_dn_wvalid", dn_wvalid, 1);
      chk("wr_wdata", dn_wdata, 32'hD000_0000 + 32'(h * 256 + i));
      chk("wr_wlast", dn_wlast, i == nbeats - 1);
      chk("wr_wready_route", up_wready, 4'b0001 << h);
      cyc();
    end
    settle();
    chk("wr_no_extra_beat", dn_wvalid, 0);
    chk("wr_no_extra_wready", up_wready, 0);
    up_wvalid[h] = 1'b0; up_wlast[h] = 1'b0; dn_wready = 1'b0;
    dn_bvalid = 1'b1; dn_bid = {hx, id}; dn_bresp = 2'b00; up_bready[h] = 1'b1;
    settle();
    chk("wr_bvalid_route", up_bvalid, 4'b0001 << h);
    chk("wr_bid", up_bid[h], id);
    chk("wr_bresp", up_bresp[h], 0);
    chk("wr_dn_bready", dn_bready, 1);
    cyc();
    dn_bvalid = 1'b0; up_bready[h] = 1'b0;
    settle();
    chk("wr_back_idle", dn_bready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int recv;
    logic hs;
    clear_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_up_awready", up_awready, 0);
    chk("rst_up_wready", up_wready, 0);
    chk("rst_up_arready", up_arready, 0);
    chk("rst_up_bvalid", up_bvalid, 0);
    chk("rst_up_rvalid", up_rvalid, 0);
    chk("rst_dn_valids", {dn_awvalid, dn_wvalid, dn_arvalid}, 0);
    chk("rst_dn_readys", {dn_bready, dn_rready}, 0);
    rst_n = 1'b1;
    cyc();

    // Test 1: host0, 4 beats; ptr goes to 0
    do_write(0, 4'h5, 32'h0000_1000, 4);

    // Host3 alone moves the pointer to 3 so the round robin below wraps to 0
    do_write(3, 4'h2, 32'h0000_3000, 1);

    // Test 2: hosts 0..2 request continuously
    for (int h = 0; h < 3; h++) begin
      up_awvalid[h] = 1'b1; up_awid[h] = 4'(h + 8); up_awlen[h] = 8'd0;
      up_wvalid[h] = 1'b1; up_wlast[h] = 1'b1; up_wdata[h] = 32'(h);
    end
    up_bready = '1; dn_awready = 1'b1; dn_wready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [1:0] e;
      e = 2'(k % 3);
      cyc();
      chk("rr_grant", dn_awid, {e, 4'(k % 3 + 8)});
      chk("rr_awready", up_awready, 4'b0001 << (k % 3));
      cyc();
      dn_bvalid = 1'b1; dn_bid = {e, 4'(k % 3 + 8)};
      settle();
      chk("rr_bvalid", up_bvalid, 4'b0001 << (k % 3));
      cyc();
      dn_bvalid = 1'b0;
    end
    clear_inputs();
    cyc();

    // Test 3: host2 W presented five cycles ahead of AW
    up_wvalid[2] = 1'b1; up_wdata[2] = 32'hCAFE_0000; up_wlast[2] = 1'b0; dn_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("early_w_held", {up_wready, 3'b000, dn_wvalid}, 0);
      cyc();
    end
    up_awvalid[2] = 1'b1; up_awid[2] = 4'hA; up_awlen[2] = 8'd1;
    cyc();
    chk("early_w_pass", dn_wvalid, 1);
    chk("early_w_data0", dn_wdata, 32'hCAFE_0000);
    chk("early_w_ready", up_wready, 4'b0100);
    cyc();
    up_wdata[2] = 32'hCAFE_0001; up_wlast[2] = 1'b1;
    settle();
    chk("early_w_data1", dn_wdata, 32'hCAFE_0001);
    cyc();
    up_wvalid[2] = 1'b0; up_wlast[2] = 1'b0; dn_wready = 1'b0;
    settle();
    chk("early_aw_still_pending", dn_awvalid, 1);
    chk("early_awid", dn_awid, {2'd2, 4'hA});
    dn_awready = 1'b1;
    cyc();
    up_awvalid[2] = 1'b0; dn_awready = 1'b0;
    dn_bvalid = 1'b1; dn_bid = {2'd2, 4'hA}; up_bready[2] = 1'b1;
    settle();
    chk("early_bvalid", up_bvalid, 4'b0100);
    chk("early_bid", up_bid[2], 4'hA);
    cyc();
    clear_inputs();
    cyc();

    // Test 4: host1 write concurrent with host3 read of 8 beats
    up_awvalid[1] = 1'b1; up_awid[1] = 4'h3; up_awlen[1] = 8'd0;
    up_wvalid[1] = 1'b1; up_wlast[1] = 1'b1; up_wdata[1] = 32'h1111_1111;
    up_arvalid[3] = 1'b1; up_arid[3] = 4'h6; up_arlen[3] = 8'd7; up_araddr[3] = 32'h8000_0000;
    cyc();
    chk("cc_awid", dn_awid, {2'd1, 4'h3});
    chk("cc_arvalid", dn_arvalid, 1);
    chk("cc_arid", dn_arid, {2'd3, 4'h6});
    chk("cc_arlen", dn_arlen, 7);
    chk("cc_araddr", dn_araddr, 32'h8000_0000);
    dn_awready = 1'b1; dn_wready = 1'b1; dn_arready = 1'b1;
    settle();
    chk("cc_arready", up_arready, 4'b1000);
    cyc();
    clear_inputs();
    up_rready[3] = 1'b1;
    recv = 0;
    for (int i = 0; i < 8; i++) begin
      dn_rvalid = 1'b1; dn_rdata = 32'h100 + 32'(i); dn_rlast = (i == 7); dn_rid = {2'd3, 4'h6};
      if (i == 0) begin
        dn_bvalid = 1'b1; dn_bid = {2'd1, 4'h3}; up_bready[1] = 1'b1;
      end
      settle();
      if (i == 0) chk("cc_bvalid", up_bvalid, 4'b0010);
      chk("cc_rvalid", up_rvalid, 4'b1000);
      chk("cc_rdata", up_rdata[3], 32'h100 + 32'(i));
      chk("cc_rlast", up_rlast[3], i == 7);
      chk("cc_rid", up_rid[3], 4'h6);
      if (up_rvalid[3] && up_rready[3]) recv++;
      cyc();
      dn_bvalid = 1'b0; up_bready[1] = 1'b0;
    end
    dn_rvalid = 1'b0; dn_rlast = 1'b0;
    settle();
    chk("cc_beats", recv, 8);
    chk("cc_read_idle", dn_rready, 0);
    clear_inputs();
    cyc();

    // Test 5: host0 read with rready held low for three cycles
    up_arvalid[0] = 1'b1; up_arid[0] = 4'h1; up_arlen[0] = 8'd3;
    cyc();
    chk("bp_arid", dn_arid, {2'd0, 4'h1});
    dn_arready = 1'b1;
    cyc();
    up_arvalid[0] = 1'b0; dn_arready = 1'b0;
    b = 0; recv = 0;
    for (int t = 0; t < 20 && b < 4; t++) begin
      dn_rvalid = 1'b1; dn_rdata = 32'h200 + 32'(b); dn_rlast = (b == 3); dn_rid = {2'd0, 4'h1};
      up_rready[0] = !(t >= 1 && t <= 3);
      settle();
      chk("bp_rready_follow", dn_rready, up_rready[0]);
      if (up_rvalid[0] && up_rready[0]) begin
        chk("bp_rdata", up_rdata[0], 32'h200 + 32'(recv));
        recv++;
      end
      hs = dn_rvalid && dn_rready;
      cyc();
      if (hs) b++;
    end
    dn_rvalid = 1'b0; dn_rlast = 1'b0; up_rready[0] = 1'b0;
    settle();
    chk("bp_beats_host", recv, 4);
    chk("bp_beats_bus", b, 4);
    chk("bp_read_idle", dn_rready, 0);
    cyc();

    // Test 6: reset during W_ACTIVE after two beats
    up_awvalid[0] = 1'b1; up_awid[0] = 4'h4; up_awlen[0] = 8'd3;
    cyc();
    dn_awready = 1'b1;
    cyc();
    up_awvalid[0] = 1'b0; dn_awready = 1'b0;
    up_wvalid[0] = 1'b1; dn_wready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      up_wdata[0] = 32'(i);
      settle();
      chk("rm_beat_pass", up_wready, 4'b0001);
      cyc();
    end
    up_awvalid[0] = 1'b1; dn_awready = 1'b1;
    rst_n = 1'b0;
    cyc();
    chk("rm_up_readys", {up_awready, up_wready, up_arready}, 0);
    chk("rm_up_valids", {up_bvalid, up_rvalid}, 0);
    chk("rm_dn_valids", {dn_awvalid, dn_wvalid, dn_arvalid}, 0);
    clear_inputs();
    rst_n = 1'b1;
    cyc();
    do_write(1, 4'h7, 32'h0000_7000, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
